// File: rtl/pool_pkg.sv
// Shared constants and state encoding for the pooled-sample stream packer.
package pool_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int PACK       = 4;
  localparam int FIFO_DEPTH = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: the head entry is visible on pop_data
// whenever empty is low. A push into a full FIFO is taken only when paired with a pop.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign rd_en = pop & ~empty & ~clear;
  assign wr_en = push & ~clear & (~full | rd_en);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage has no reset; stale entries are never visible because empty gates them.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pool_stream_packer.sv
// Packs pooled samples into PACK-lane words, buffers them in a FWFT FIFO and
// presents them as a valid/ready stream with keep/last, flagging dropped words.
module pool_stream_packer
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH,
  parameter int PACK       = pool_pkg::PACK,
  parameter int FIFO_DEPTH = pool_pkg::FIFO_DEPTH
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clear,
  input  logic                       i_valid,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_done,
  output logic [DATA_WIDTH*PACK-1:0] o_tdata,
  output logic [PACK-1:0]            o_tkeep,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       i_tready,
  output logic                       o_overflow,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic [15:0]                o_word_cnt
);

  localparam int LANE_W = $clog2(PACK);
  localparam int WORD_W = DATA_WIDTH*PACK + PACK + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                                 last;
    logic [PACK-1:0]                      keep;
    logic [PACK-1:0][DATA_WIDTH-1:0]      data;
  } word_t;

  logic [PACK-1:0][DATA_WIDTH-1:0] lanes;
  logic [LANE_W-1:0]               lane_cnt;
  logic [LANE_W:0]                 filled;
  word_t                           push_word;
  word_t                           pop_word;
  logic [WORD_W-1:0]               pop_bits;
  logic                            push;
  logic                            pop;
  logic                            drop;
  logic                            last_kept;
  logic                            pop_last;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic [CNT_W-1:0]                fifo_count;
  state_e                          state;
  state_e                          state_next;

  // Word being completed this cycle: buffered lanes plus the current sample.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_word.data = lanes;
    if (i_valid) push_word.data[lane_cnt] = i_data;
    filled = {1'b0, lane_cnt} + (LANE_W+1)'(i_valid);
    for (int i = 0; i < PACK; i++) push_word.keep[i] = (i < int'(filled));
    push_word.last = i_done;
  end

  assign push      = ~i_clear & ((i_valid & (lane_cnt == LANE_W'(PACK-1))) | i_done);
  assign pop       = o_tvalid & i_tready;
  assign drop      = push & fifo_full & ~pop;
  assign last_kept = push & push_word.last & ~drop;
  assign pop_word  = word_t'(pop_bits);
  assign pop_last  = pop & pop_word.last;

  sync_fifo_fwft #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .clear     (i_clear),
    .push      (push),
    .push_data (push_word),
    .pop       (pop),
    .pop_data  (pop_bits),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Lanes are zeroed after every push so a partial word carries zero in unused lanes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lanes    <= '0;
      lane_cnt <= '0;
    end else if (i_clear || push) begin
      lanes    <= '0;
      lane_cnt <= '0;
    end else if (i_valid) begin
      lanes[lane_cnt] <= i_data;
      lane_cnt        <= lane_cnt + LANE_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)       state <= COLLECT;
    else if (i_clear) state <= COLLECT;
    else              state <= state_next;
  end

  // A dropped last word ends the frame without entering DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (last_kept) state_next = DRAIN;
      DRAIN:   if (pop_last)  state_next = last_kept ? DRAIN : COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  always_comb begin
    o_busy = (state == DRAIN) | (lane_cnt != '0) | (fifo_count != '0);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_cnt   <= '0;
    end else if (i_clear) begin
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_cnt   <= '0;
    end else begin
      o_frame_done <= pop_last;
      if (drop) o_overflow <= 1'b1;
      if (pop)  o_word_cnt <= o_word_cnt + 16'd1;
    end
  end

  // Unreset FIFO storage never reaches the outputs while empty.
  assign o_tvalid = ~fifo_empty;
  assign o_tdata  = fifo_empty ? '0 : pop_word.data;
  assign o_tkeep  = fifo_empty ? '0 : pop_word.keep;
  assign o_tlast  = fifo_empty ? 1'b0 : pop_word.last;

endmodule

// File: tb/tb_pool_stream_packer.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor pops and
// compares them on every handshake and checks the frame_done pulse timing.
module tb_pool_stream_packer;

  logic        i_clk;
  logic        i_rst;
  logic        i_clear;
  logic        i_valid;
  logic [15:0] i_data;
  logic        i_done;
  logic [63:0] o_tdata;
  logic [3:0]  o_tkeep;
  logic        o_tlast;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_overflow;
  logic        o_busy;
  logic        o_frame_done;
  logic [15:0] o_word_cnt;

  pool_stream_packer dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clear      (i_clear),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_done       (i_done),
    .o_tdata      (o_tdata),
    .o_tkeep      (o_tkeep),
    .o_tlast      (o_tlast),
    .o_tvalid     (o_tvalid),
    .i_tready     (i_tready),
    .o_overflow   (o_overflow),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_word_cnt   (o_word_cnt)
  );

  typedef struct {
    logic [63:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   fd_seen  = 0;
  logic exp_fd   = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic dn);
    i_valid = v;
    i_data  = d;
    i_done  = dn;
    tick();
    i_valid = 1'b0;
    i_data  = 16'h0;
    i_done  = 1'b0;
  endtask

  task automatic exp_word(input logic [63:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.data = d;
    e.keep = k;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic exp_seq(input logic [15:0] b, input logic l);
    exp_word({b + 16'd3, b + 16'd2, b + 16'd1, b}, 4'hF, l);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
    check("drain_done", 64'(sb.size()), 64'd0);
    repeat (3) tick();
  endtask

  task automatic do_clear();
    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
  endtask

  // Monitor: compares each accepted word and expects frame_done the cycle after a last word.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      exp_fd = 1'b0;
    end else begin
      if (exp_fd || o_frame_done) check("frame_done", 64'(o_frame_done), 64'(exp_fd));
      if (o_frame_done) fd_seen++;
      exp_fd = 1'b0;
      if (o_tvalid && i_tready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got 0x%0h with no word expected", o_tdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("word_data", o_tdata, e.data);
          check("word_keep", 64'(o_tkeep), 64'(e.keep));
          check("word_last", 64'(o_tlast), 64'(e.last));
          exp_fd = e.last;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst    = 1'b0;
    i_clear  = 1'b0;
    i_valid  = 1'b0;
    i_data   = 16'h0;
    i_done   = 1'b0;
    i_tready = 1'b0;

    // Reset state
    #12;
    check("rst_tvalid", 64'(o_tvalid), 64'd0);
    check("rst_tdata", o_tdata, 64'd0);
    check("rst_tkeep", 64'(o_tkeep), 64'd0);
    check("rst_tlast", 64'(o_tlast), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_overflow", 64'(o_overflow), 64'd0);
    check("rst_frame_done", 64'(o_frame_done), 64'd0);
    check("rst_word_cnt", 64'(o_word_cnt), 64'd0);
    #1 i_rst = 1'b1;
    tick();

    // Frame of 8 samples, done together with the 8th
    i_tready = 1'b1;
    exp_word(64'h0004_0003_0002_0001, 4'hF, 1'b0);
    exp_word(64'h0008_0007_0006_0005, 4'hF, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 16'(k), k == 8);
      if (k == 4) begin
        check("latency_tvalid", 64'(o_tvalid), 64'd1);
        check("latency_tdata", o_tdata, 64'h0004_0003_0002_0001);
      end
    end
    wait_drain();
    check("t1_word_cnt", 64'(o_word_cnt), 64'd2);
    check("t1_fd_seen", 64'(fd_seen), 64'd1);
    check("t1_busy_idle", 64'(o_busy), 64'd0);

    // Six samples then done alone: partial word with keep 0x3
    exp_word(64'h0013_0012_0011_0010, 4'hF, 1'b0);
    exp_word(64'h0000_0000_0015_0014, 4'h3, 1'b1);
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 16'h0010 + 16'(k), 1'b0);
      if (k == 1) check("t2_busy_partial", 64'(o_busy), 64'd1);
    end
    drive(1'b0, 16'h0, 1'b1);
    wait_drain();
    check("t2_word_cnt", 64'(o_word_cnt), 64'd4);

    // Four samples then done alone: full word plus terminator
    exp_word(64'h0023_0022_0021_0020, 4'hF, 1'b0);
    exp_word(64'h0, 4'h0, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 16'h0020 + 16'(k), 1'b0);
    drive(1'b0, 16'h0, 1'b1);
    wait_drain();
    check("t3_word_cnt", 64'(o_word_cnt), 64'd6);
    check("t3_fd_seen", 64'(fd_seen), 64'd3);

    // Clear, then 80 samples with a stalled sink: 16 words kept, 4 dropped
    do_clear();
    check("clr_word_cnt", 64'(o_word_cnt), 64'd0);
    i_tready = 1'b0;
    for (int j = 0; j < 16; j++) exp_seq(16'h0100 + 16'(4*j), 1'b0);
    for (int k = 0; k < 80; k++) drive(1'b1, 16'h0100 + 16'(k), 1'b0);
    check("ovf_set", 64'(o_overflow), 64'd1);
    check("ovf_tvalid", 64'(o_tvalid), 64'd1);
    check("ovf_head", o_tdata, 64'h0103_0102_0101_0100);
    i_tready = 1'b1;
    wait_drain();
    check("ovf_word_cnt", 64'(o_word_cnt), 64'd16);
    check("ovf_sticky", 64'(o_overflow), 64'd1);
    do_clear();
    check("ovf_cleared", 64'(o_overflow), 64'd0);

    // Fill to full, then push+pop on a full FIFO under random ready
    i_tready = 1'b0;
    for (int j = 0; j < 16; j++) exp_seq(16'h0200 + 16'(4*j), 1'b0);
    for (int j = 0; j < 9; j++) exp_seq(16'h0240 + 16'(4*j), j == 8);
    for (int k = 0; k < 64; k++) drive(1'b1, 16'h0200 + 16'(k), 1'b0);
    check("full_no_ovf", 64'(o_overflow), 64'd0);
    for (int k = 0; k < 36; k++) begin
      if (k < 3)           i_tready = 1'b0;
      else if (k % 4 == 3) i_tready = 1'b1;
      else                 i_tready = 1'($urandom_range(0, 1));
      drive(1'b1, 16'h0240 + 16'(k), k == 35);
      if (k == 3) check("full_pushpop_no_ovf", 64'(o_overflow), 64'd0);
    end
    i_tready = 1'b1;
    wait_drain();
    check("rand_no_ovf", 64'(o_overflow), 64'd0);
    check("rand_word_cnt", 64'(o_word_cnt), 64'd25);

    // Reset mid-frame with a word stuck in the FIFO
    i_tready = 1'b0;
    exp_seq(16'h0030, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 16'h0030 + 16'(k), k == 3);
    for (int k = 4; k < 7; k++) drive(1'b1, 16'h0030 + 16'(k), 1'b0);
    check("pre_rst_tvalid", 64'(o_tvalid), 64'd1);
    #2 i_rst = 1'b0;
    sb.delete();
    #1;
    check("midrst_tvalid", 64'(o_tvalid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_word_cnt", 64'(o_word_cnt), 64'd0);
    #2 i_rst = 1'b1;
    tick();
    i_tready = 1'b1;
    exp_seq(16'h0040, 1'b1);
    for (int k = 0; k < 4; k++) drive(1'b1, 16'h0040 + 16'(k), k == 3);
    wait_drain();
    check("post_rst_word_cnt", 64'(o_word_cnt), 64'd1);
    check("total_fd_seen", 64'(fd_seen), 64'd5);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
